// File: rtl/cpu_bus_master_pkg.sv
// Shared types and defaults for the NES/Famicom CPU-side cartridge bus master.
package cpu_bus_master_pkg;

    localparam int PHI1_CLKS_DEF = 6;
    localparam int PHI2_CLKS_DEF = 6;
    localparam int IRQ_SYNC_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARMED  = 2'b01,
        ST_ACTIVE = 2'b10,
        ST_HOLD   = 2'b11
    } bus_state_e;

    function automatic int period_clks(input int phi1, input int phi2);
        return phi1 + phi2;
    endfunction

endpackage

// File: rtl/cpu_bus_master_phase_gen.sv
// Free-running m2 generator: PHI1_CLKS clocks low, PHI2_CLKS clocks high.
// Strobes mark the last clk of each phase so registered bus outputs can switch on phase edges.
module cpu_bus_master_phase_gen
    import cpu_bus_master_pkg::*;
#(
    parameter int PHI1_CLKS = PHI1_CLKS_DEF,
    parameter int PHI2_CLKS = PHI2_CLKS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    output logic m2_o,
    output logic last_phi1_o,
    output logic last_phi2_o
);

    localparam int P  = period_clks(PHI1_CLKS, PHI2_CLKS);
    localparam int CW = $clog2(P);
    localparam logic [CW-1:0] CNT_LAST       = CW'(P - 1);
    localparam logic [CW-1:0] CNT_PHI1_LAST  = CW'(PHI1_CLKS - 1);
    localparam logic [CW-1:0] CNT_PHI2_FIRST = CW'(PHI1_CLKS);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          m2_q;
    logic          m2_d;

    // Next phase count; m2 is decoded from it so the m2 flop stays aligned with cnt_q.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        m2_d = (cnt_d >= CNT_PHI2_FIRST);
    end

    // Phase counter and m2 registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
            m2_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            m2_q  <= m2_d;
        end
    end

    assign m2_o        = m2_q;
    assign last_phi1_o = (cnt_q == CNT_PHI1_LAST);
    assign last_phi2_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/cpu_bus_master.sv
// Request/response host port to NES/Famicom cartridge CPU bus cycles, one transaction per m2 period,
// plus a synchronizer bringing the cart /IRQ back into the clk domain.
module cpu_bus_master
    import cpu_bus_master_pkg::*;
#(
    parameter int PHI1_CLKS = PHI1_CLKS_DEF,
    parameter int PHI2_CLKS = PHI2_CLKS_DEF,
    parameter int IRQ_SYNC  = IRQ_SYNC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        resp_valid,
    output logic [7:0]  resp_rdata,
    output logic        m2,
    output logic        romsel,
    output logic        cpu_rw,
    output logic [14:0] cpu_addr,
    output logic [7:0]  cpu_data_out,
    output logic        cpu_data_oe,
    input  logic [7:0]  cpu_data_in,
    input  logic        irq_n,
    output logic        irq
);

    logic last_phi1_s;
    logic last_phi2_s;
    logic m2_s;

    cpu_bus_master_phase_gen #(
        .PHI1_CLKS (PHI1_CLKS),
        .PHI2_CLKS (PHI2_CLKS)
    ) u_phase_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .m2_o        (m2_s),
        .last_phi1_o (last_phi1_s),
        .last_phi2_o (last_phi2_s)
    );

    bus_state_e        state_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic [7:0]        resp_rdata_q;
    logic              lat_rw_q;
    logic [15:0]       lat_addr_q;
    logic [7:0]        lat_wdata_q;
    logic              romsel_q;
    logic              cpu_rw_q;
    logic [14:0]       cpu_addr_q;
    logic [7:0]        cpu_data_out_q;
    logic              cpu_data_oe_q;
    logic [IRQ_SYNC-1:0] irq_sync_q;
    logic              accept_s;

    assign accept_s = req_valid & req_ready_q;

    // Transaction FSM; every bus output is registered so it switches exactly on phase boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= 8'h00;
            lat_rw_q       <= 1'b1;
            lat_addr_q     <= 16'h0000;
            lat_wdata_q    <= 8'h00;
            romsel_q       <= 1'b1;
            cpu_rw_q       <= 1'b1;
            cpu_addr_q     <= 15'h0000;
            cpu_data_out_q <= 8'h00;
            cpu_data_oe_q  <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        lat_rw_q    <= req_rw;
                        lat_addr_q  <= req_addr;
                        lat_wdata_q <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Only a whole period may be used, so launch exactly at the next period start.
                    if (last_phi2_s) begin
                        cpu_addr_q <= lat_addr_q[14:0];
                        cpu_rw_q   <= lat_rw_q;
                        state_q    <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (last_phi1_s) begin
                        romsel_q      <= ~lat_addr_q[15];
                        cpu_data_oe_q <= ~lat_rw_q;
                        if (!lat_rw_q) begin
                            cpu_data_out_q <= lat_wdata_q;
                        end
                    end
                    if (last_phi2_s) begin
                        romsel_q <= 1'b1;
                        if (lat_rw_q) begin
                            resp_rdata_q <= cpu_data_in;
                        end
                        resp_valid_q <= 1'b1;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Write data stays driven for one clk after m2 falls to cover cart hold time.
                    cpu_rw_q      <= 1'b1;
                    cpu_data_oe_q <= 1'b0;
                    if (accept_s) begin
                        lat_rw_q    <= req_rw;
                        lat_addr_q  <= req_addr;
                        lat_wdata_q <= req_wdata;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_ARMED;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q       <= ST_IDLE;
                    req_ready_q   <= 1'b1;
                    romsel_q      <= 1'b1;
                    cpu_rw_q      <= 1'b1;
                    cpu_data_oe_q <= 1'b0;
                end
            endcase
        end
    end

    // Cart /IRQ synchronizer, inverted to active-high on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_sync_q <= {IRQ_SYNC{1'b0}};
        end else begin
            irq_sync_q <= {irq_sync_q[IRQ_SYNC-2:0], ~irq_n};
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign m2           = m2_s;
    assign romsel       = romsel_q;
    assign cpu_rw       = cpu_rw_q;
    assign cpu_addr     = cpu_addr_q;
    assign cpu_data_out = cpu_data_out_q;
    assign cpu_data_oe  = cpu_data_oe_q;
    assign irq          = irq_sync_q[IRQ_SYNC-1];

endmodule
